alu_exec_unit: RTL and testbench

//  Execute-stage ALU sitting directly downstream of ALU_Control: consumes its 4-bit Control_out

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_exec_unit_if.sv | 27 ++
 rtl/alu_shift_seq.sv | 45 ++++
 rtl/alu_exec_unit.sv | 114 +++++++++++
 tb/tb_alu_exec_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ALU op-code and execute-FSM encodings, shared with ALU_Control.
// Shift codes are only executed as shifts when ALU_SHIFT_EN is defined.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle for the execute-stage ALU.
// master drives requests and accepts results; slave is the ALU.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);

    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, alu_ctrl, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_ctrl, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero
    );

endinterface

// File: rtl/alu_shift_seq.sv
// Iterative shifter: loads acc/cnt on start, moves one bit per step.
// Only instantiated when ALU_SHIFT_EN is defined.
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic [3:0]         op,
    input  logic [XLEN-1:0]    din,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [XLEN-1:0]    acc,
    output logic               done
);

    logic [SHAMT_W-1:0] cnt;
    logic [3:0]         op_q;

    // done flags the step that takes cnt from 1 to 0
    assign done = step && (cnt == SHAMT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            cnt  <= '0;
            op_q <= ALU_SLL;
        end else if (start) begin
            acc  <= din;
            cnt  <= shamt;
            op_q <= op;
        end else if (step) begin
            cnt <= cnt - SHAMT_W'(1);
            unique case (1'b1)
                (op_q == ALU_SLL): acc <= {acc[XLEN-2:0], 1'b0};
                (op_q == ALU_SRL): acc <= {1'b0, acc[XLEN-1:1]};
                default:           acc <= {acc[XLEN-1], acc[XLEN-1:1]};
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with valid/ready in and out.
// Define ALU_SHIFT_EN to add iterative SLL/SRL/SRA (one bit per cycle).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus,
    output logic           busy
);

    state_t          state;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic [XLEN-1:0] alu_res;
    logic            accept;
    logic            shift_go;
    logic [XLEN-1:0] sh_acc;
    logic            sh_done;

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.in_ready  = (state == ST_IDLE)
                         && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        alu_res = bus.src_a + bus.src_b;
        case (bus.alu_ctrl)
            ALU_AND: alu_res = bus.src_a & bus.src_b;
            ALU_OR:  alu_res = bus.src_a | bus.src_b;
            ALU_SUB: alu_res = bus.src_a - bus.src_b;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}},
                                $signed(bus.src_a) < $signed(bus.src_b)};
`ifdef ALU_SHIFT_EN
            // only reached as a 1-cycle op when shamt is zero
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = bus.src_a;
`endif
            default: alu_res = bus.src_a + bus.src_b;
        endcase
    end

`ifdef ALU_SHIFT_EN
    localparam int SHAMT_W = $clog2(XLEN);

    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;

    assign shamt    = bus.src_b[SHAMT_W-1:0];
    assign is_shift = (bus.alu_ctrl == ALU_SLL)
                   || (bus.alu_ctrl == ALU_SRL)
                   || (bus.alu_ctrl == ALU_SRA);
    assign shift_go = accept && is_shift && (shamt != '0);
    assign busy     = (state != ST_IDLE);

    alu_shift_seq #(
        .XLEN (XLEN)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .start (shift_go),
        .step  (state == ST_SHIFT),
        .op    (bus.alu_ctrl),
        .din   (bus.src_a),
        .shamt (shamt),
        .acc   (sh_acc),
        .done  (sh_done)
    );
`else
    assign shift_go = 1'b0;
    assign sh_acc   = '0;
    assign sh_done  = 1'b0;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (shift_go) begin
                        state       <= ST_SHIFT;
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        result_q    <= alu_res;
                        zero_q      <= (alu_res == '0);
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) state <= ST_DONE;
                end
                ST_DONE: begin
                    result_q    <= sh_acc;
                    zero_q      <= (sh_acc == '0);
                    out_valid_q <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
// Shift tests are compiled in only when ALU_SHIFT_EN is defined.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;

    alu_exec_unit_if #(.XLEN(32)) bus();

    alu_exec_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.out_valid && bus.out_ready) xfers++;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; issues one request, returns at the next negedge
    task automatic send(input logic [3:0] c,
                        input logic [31:0] a,
                        input logic [31:0] b);
        bus.alu_ctrl = c;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.in_valid = 1'b1;
        #1;
        check("send_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.alu_ctrl  = ALU_ADD;
        bus.src_a     = '0;
        bus.src_b     = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // reset mid-stream, with a result pending
        bus.out_ready = 1'b0;
        send(ALU_ADD, 32'd1, 32'd1);
        check("pend_valid", 32'(bus.out_valid), 32'd1);
        check("pend_result", bus.result, 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_result", bus.result, 32'd0);
        check("mid_rst_zero", 32'(bus.zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // SUB then ADD back-to-back
        send(ALU_SUB, 32'd5, 32'd5);
        check("sub_valid", 32'(bus.out_valid), 32'd1);
        check("sub_result", bus.result, 32'd0);
        check("sub_zero", 32'(bus.zero), 32'd1);
        send(ALU_ADD, 32'd7, 32'd8);
        check("add_valid", 32'(bus.out_valid), 32'd1);
        check("add_result", bus.result, 32'd15);
        check("add_zero", 32'(bus.zero), 32'd0);

        send(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg", bus.result, 32'd1);
        send(ALU_SLT, 32'd1, 32'hFFFF_FFFF);
        check("slt_pos", bus.result, 32'd0);
        check("slt_zero", 32'(bus.zero), 32'd1);
        send(ALU_AND, 32'h0000_00F0, 32'h0000_003C);
        check("and_result", bus.result, 32'h0000_0030);
        send(4'b1111, 32'd2, 32'd3);
        check("unk_result", bus.result, 32'd5);
        send(ALU_SUB, 32'd0, 32'd1);
        check("sub_wrap", bus.result, 32'hFFFF_FFFF);
        send(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap", bus.result, 32'd0);
        check("add_wrap_zero", 32'(bus.zero), 32'd1);
        @(negedge clk);
        check("idle_valid", 32'(bus.out_valid), 32'd0);

        // backpressure: result frozen, new request held off
        bus.out_ready = 1'b0;
        send(ALU_OR, 32'h1, 32'h2);
        x0 = xfers;
        bus.alu_ctrl = ALU_ADD;
        bus.src_a    = 32'd10;
        bus.src_b    = 32'd10;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result", bus.result, 32'd3);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain", 32'(bus.out_valid), 32'd0);
        check("bp_xfers", 32'(xfers - x0), 32'd1);

`ifdef ALU_SHIFT_EN
        begin
            int bcnt;
            bit got;
            bcnt = 0;
            got  = 1'b0;
            send(ALU_SRA, 32'h8000_0000, 32'd4);
            for (int i = 0; i < 40 && !got; i++) begin
                if (bus.out_valid) got = 1'b1;
                else begin
                    if (busy) bcnt++;
                    check("sra_no_ready", 32'(bus.in_ready), 32'd0);
                    @(negedge clk);
                end
            end
            check("sra_done", 32'(got), 32'd1);
            check("sra_busy_cycles", 32'(bcnt), 32'd5);
            check("sra_result", bus.result, 32'hF800_0000);
            check("sra_busy_after", 32'(busy), 32'd0);

            send(ALU_SRL, 32'h8000_0000, 32'd3);
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++)
                if (bus.out_valid) got = 1'b1;
                else @(negedge clk);
            check("srl_result", bus.result, 32'h1000_0000);

            send(ALU_SLL, 32'h0000_1234, 32'd0);
            check("sll0_valid", 32'(bus.out_valid), 32'd1);
            check("sll0_result", bus.result, 32'h0000_1234);
            check("sll0_busy", 32'(busy), 32'd0);

            // reset during SHIFT drops the op
            send(ALU_SLL, 32'd1, 32'd8);
            repeat (3) @(negedge clk);
            check("sh_busy_mid", 32'(busy), 32'd1);
            rst_n = 1'b0;
            #1;
            check("sh_rst_busy", 32'(busy), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (bus.out_valid) got = 1'b1;
            end
            check("sh_rst_no_valid", 32'(got), 32'd0);
            send(ALU_ADD, 32'd1, 32'd1);
            check("sh_rst_add", bus.result, 32'd2);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
